video_capture_dma_packer: RTL and testbench
===========================================

Name: video_capture_dma_packer

Overview:
- Write-direction counterpart of the display path: the display path consumes a 64-bit DMA read stream; this block produces a 64-bit DMA write stream.
- Takes a frame-synchronised pixel stream from a capture front-end, packs pixels little-endian into 64-bit words and buffers them in a small FIFO.
- Presents the words to the DMA write channel with valid/ready/keep/last handshake, plus status counters that feed an APB3 read-register bank.

Parameters:
- PIX_W, 32, pixel width in bits; legal values 16 or 32; PPW = 64/PIX_W pixels per word.
- FRAME_PIXELS, 921600, pixels per frame (1280x720); need not be a multiple of PPW.
- FIFO_DEPTH, 16, output FIFO depth in words; power of 2, >=4.

Ports:
- clk  in  1  single clock domain.
- resetn  in  1  asynchronous, active-low reset.
- i_enable  in  1  capture enable (level).
- i_clear  in  1  1-cycle pulse; clears sticky flags and drop_count.
- i_vsync  in  1  1-cycle frame-start pulse.
- i_valid  in  1  pixel qualifier; the source cannot be stalled.
- i_pixel  in  PIX_W  pixel data.
- dma_wdata  out  64  packed word.
- dma_wvalid  out  1  word available.
- dma_wready  in  1  DMA accepts the word.
- dma_wkeep  out  8  byte enables.
- dma_wlast  out  1  last word of frame.
- o_frame_count  out  16  frames written into FIFO; wraps.
- o_drop_count  out  16  words dropped on FIFO full; saturates at 0xFFFF.
- o_overflow  out  1  sticky: any word dropped.
- o_short_frame  out  1  sticky: a frame was truncated by i_vsync.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0, FIFO empty, packer empty, state IDLE.
- FSM states:
  - IDLE: pixels ignored. When i_enable=1, go to WAIT_VS.
  - WAIT_VS: i_vsync -> CAPTURE, pixel counter cleared. A pixel with i_valid in the same cycle as i_vsync is pixel 0.
  - CAPTURE: each i_valid pixel is placed at bits [k*PIX_W +: PIX_W], where k = pixel index mod PPW.
    - A word is pushed when PPW pixels are collected, or on the frame's final pixel.
    - On the final pixel: unfilled bytes are 0, keep covers only filled bytes (e.g. 0x0F for one 32-bit pixel), last=1.
    - After the final pixel: go to WAIT_VS if i_enable=1, else IDLE.
  - Deassertion of i_enable mid-frame does not abort the frame; the frame completes first.
- Early i_vsync in CAPTURE (before FRAME_PIXELS pixels):
  - If the packer is non-empty, push the partial word with last=1.
  - If the packer is empty, push a word with data 0, keep 0x00, last=1.
  - Set o_short_frame, increment o_frame_count, restart the counter.
  - A pixel valid in that cycle is pixel 0 of the new frame.
- Push latency: word enters the FIFO one cycle after its completing pixel. dma_wvalid asserts the following cycle if the FIFO was empty (2-cycle pixel-to-valid minimum).
- FIFO:
  - Stores {last, keep, data}. dma_wvalid = !empty. Pop when dma_wvalid & dma_wready.
  - Outputs held stable while dma_wvalid=1 and dma_wready=0.
  - Simultaneous push and pop when full is accepted (no drop).
- Push while full (and no pop):
  - The word is discarded, even if it carries last.
  - o_overflow set; o_drop_count +1, saturating.
  - o_frame_count still increments on a discarded last word.
- o_frame_count increments on every last-word push attempt; wraps 0xFFFF -> 0.
- i_clear clears o_overflow, o_short_frame and o_drop_count next cycle. If a drop coincides with i_clear, the drop wins: o_drop_count=1, o_overflow=1.
- Async reset mid-frame: FIFO contents discarded, all outputs return to reset values immediately.

Test Plan:
- PIX_W=32, FRAME_PIXELS=4, dma_wready=1, enable, vsync, pixels 0x11111111..0x44444444 -> two words:
  - 0x22222222_11111111, keep 0xFF, last 0.
  - 0x44444444_33333333, keep 0xFF, last 1.
  - o_frame_count=1.
- FRAME_PIXELS=3, pixels 0x11111111..0x33333333 -> second word 0x00000000_33333333, keep 0x0F, last 1; PIX_W=16, FRAME_PIXELS=5 -> second word keep 0x03.
- FRAME_PIXELS=4, vsync after one pixel 0xAAAAAAAA -> word 0x00000000_AAAAAAAA, keep 0x0F, last 1; o_short_frame=1; next 4 pixels form a full frame.
- FIFO_DEPTH=4, dma_wready=0, 12 pixels -> 4 words held, o_overflow=1, o_drop_count=2; i_clear -> both 0; draining returns the first 4 words in order.
- Random dma_wready toggling over 3 frames -> all data in order, no loss, outputs stable during stalls, o_drop_count=0.
- Pixels before vsync, or with i_enable=0, are ignored. Reset asserted mid-frame -> outputs 0, o_busy=0, no word until enable plus a new vsync.

Source files
------------

// File: rtl/video_capture_dma_packer.sv
// Capture-side pixel packer: frames a synchronised pixel stream, packs pixels
// little-endian into 64-bit words and queues them for a DMA write channel.
module video_capture_dma_packer #(
    parameter int PIX_W        = 32,
    parameter int FRAME_PIXELS = 921600,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic             i_vsync,
    input  logic             i_valid,
    input  logic [PIX_W-1:0] i_pixel,
    output logic [63:0]      dma_wdata,
    output logic             dma_wvalid,
    input  logic             dma_wready,
    output logic [7:0]       dma_wkeep,
    output logic             dma_wlast,
    output logic [15:0]      o_frame_count,
    output logic [15:0]      o_drop_count,
    output logic             o_overflow,
    output logic             o_short_frame,
    output logic             o_busy
);
    localparam int PPW    = 64 / PIX_W;
    localparam int KB     = PIX_W / 8;
    localparam int CNT_W  = $clog2(FRAME_PIXELS + 1);
    localparam int SLOT_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam logic [7:0] PIX_KEEP = 8'((1 << KB) - 1);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  pix_cnt;
    logic [SLOT_W-1:0] slot;
    logic [63:0]       pack_data;
    logic [7:0]        pack_keep;

    // staged word, written into the FIFO the cycle after it is formed
    logic              st_valid;
    logic              st_last;
    logic [63:0]       st_data;
    logic [7:0]        st_keep;

    logic              start_frame, truncate, take, word_full, frame_end;
    logic [SLOT_W-1:0] cur_slot;
    logic [CNT_W-1:0]  cur_cnt;
    logic [63:0]       base_data, new_data;
    logic [7:0]        base_keep, new_keep;

    // Pixel placement: a vsync restarts the frame, so the pixel in that cycle lands in slot 0
    always_comb begin
        start_frame = i_vsync && (state == WAIT_VS || state == CAPTURE);
        truncate    = i_vsync && (state == CAPTURE);
        take        = i_valid && (start_frame || state == CAPTURE);
        cur_slot    = start_frame ? '0 : slot;
        cur_cnt     = start_frame ? '0 : pix_cnt;
        base_data   = start_frame ? '0 : pack_data;
        base_keep   = start_frame ? '0 : pack_keep;
        new_data    = base_data | (64'(i_pixel) << (int'(cur_slot) * PIX_W));
        new_keep    = base_keep | (PIX_KEEP << (int'(cur_slot) * KB));
        word_full   = (int'(cur_slot) == PPW - 1);
        frame_end   = (cur_cnt == CNT_W'(FRAME_PIXELS - 1));
    end

    // Frame FSM, packer and word staging
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            pix_cnt   <= '0;
            slot      <= '0;
            pack_data <= '0;
            pack_keep <= '0;
            st_valid  <= 1'b0;
            st_last   <= 1'b0;
            st_data   <= '0;
            st_keep   <= '0;
        end else begin
            st_valid <= 1'b0;
            case (state)
                IDLE:    if (i_enable) state <= WAIT_VS;
                WAIT_VS: if (start_frame) state <= CAPTURE;
                         else if (!i_enable) state <= IDLE;
                CAPTURE: ;
                default: state <= IDLE;
            endcase
            if (start_frame) begin
                pix_cnt   <= '0;
                slot      <= '0;
                pack_data <= '0;
                pack_keep <= '0;
                // an empty packer yields a zero word with keep 0, still marking last
                if (truncate) begin
                    st_valid <= 1'b1;
                    st_data  <= pack_data;
                    st_keep  <= pack_keep;
                    st_last  <= 1'b1;
                end
            end
            if (take) begin
                if (word_full || frame_end) begin
                    st_valid  <= 1'b1;
                    st_data   <= new_data;
                    st_keep   <= new_keep;
                    st_last   <= frame_end;
                    pack_data <= '0;
                    pack_keep <= '0;
                    slot      <= '0;
                end else begin
                    pack_data <= new_data;
                    pack_keep <= new_keep;
                    slot      <= cur_slot + 1'b1;
                end
                if (frame_end) begin
                    pix_cnt <= '0;
                    state   <= i_enable ? WAIT_VS : IDLE;
                end else begin
                    pix_cnt <= cur_cnt + 1'b1;
                end
            end
        end
    end

    assign o_busy = (state != IDLE);

    logic [AW:0] wr_ptr, rd_ptr;
    logic [72:0] mem [FIFO_DEPTH];
    logic [72:0] head;
    logic        empty, full, pop, push_ok, drop;

    // FIFO status and handshake decode
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop     = !empty && dma_wready;
        push_ok = st_valid && (!full || pop);
        drop    = st_valid && full && !pop;
        head    = mem[rd_ptr[AW-1:0]];
    end

    assign dma_wvalid = !empty;
    assign dma_wdata  = empty ? '0 : head[63:0];
    assign dma_wkeep  = empty ? '0 : head[71:64];
    assign dma_wlast  = empty ? 1'b0 : head[72];

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= {st_last, st_keep, st_data};
    end

    // FIFO pointers and status counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            o_frame_count <= '0;
            o_drop_count  <= '0;
            o_overflow    <= 1'b0;
            o_short_frame <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (st_valid && st_last) o_frame_count <= o_frame_count + 1'b1;
            // a drop or truncation in the clear cycle survives the clear
            if (i_clear) begin
                o_overflow    <= drop;
                o_drop_count  <= drop ? 16'd1 : '0;
                o_short_frame <= truncate;
            end else begin
                if (drop) begin
                    o_overflow <= 1'b1;
                    if (o_drop_count != '1) o_drop_count <= o_drop_count + 1'b1;
                end
                if (truncate) o_short_frame <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_video_capture_dma_packer.sv
// Directed + randomized bench for video_capture_dma_packer (32-bit pixels,
// 5-pixel frames, 4-deep FIFO) with a frame-level reference model.
module tb_video_capture_dma_packer;
    localparam int PIX_W = 32;
    localparam int FP    = 5;
    localparam int DEPTH = 4;
    localparam int PPW   = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_enable = 1'b0, i_clear = 1'b0, i_vsync = 1'b0, i_valid = 1'b0;
    logic [31:0] i_pixel = '0;
    logic [63:0] dma_wdata;
    logic        dma_wvalid, dma_wlast;
    logic        dma_wready = 1'b1;
    logic [7:0]  dma_wkeep;
    logic [15:0] o_frame_count, o_drop_count;
    logic        o_overflow, o_short_frame, o_busy;

    always #5 clk = ~clk;

    video_capture_dma_packer #(.PIX_W(PIX_W), .FRAME_PIXELS(FP), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .i_enable(i_enable), .i_clear(i_clear),
        .i_vsync(i_vsync), .i_valid(i_valid), .i_pixel(i_pixel),
        .dma_wdata(dma_wdata), .dma_wvalid(dma_wvalid), .dma_wready(dma_wready),
        .dma_wkeep(dma_wkeep), .dma_wlast(dma_wlast),
        .o_frame_count(o_frame_count), .o_drop_count(o_drop_count),
        .o_overflow(o_overflow), .o_short_frame(o_short_frame), .o_busy(o_busy)
    );

    int          errors = 0;
    int          checks = 0;
    logic [72:0] exp_q[$];
    logic [72:0] obs_q[$];
    logic [31:0] frame_q[$];
    bit          m_cap = 0;
    bit          m_armed = 0;
    logic [15:0] m_frames = '0;
    bit          rand_ready = 0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Split the frame's pixels into little-endian words; a truncated frame
    // whose pixels filled whole words gets an extra empty last word.
    task automatic emit(input bit truncated);
        int n, nw;
        logic [63:0] d;
        logic [7:0]  k;
        n  = frame_q.size();
        nw = (n + PPW - 1) / PPW;
        if (truncated && (n % PPW == 0)) nw = nw + 1;
        for (int j = 0; j < nw; j++) begin
            d = '0;
            k = '0;
            for (int s = 0; s < PPW; s++)
                if (j * PPW + s < n) begin
                    d[s*32 +: 32] = frame_q[j * PPW + s];
                    k[s*4 +: 4]   = 4'hF;
                end
            exp_q.push_back({(j == nw - 1), k, d});
        end
        frame_q.delete();
        m_frames++;
    endtask

    task automatic step(input bit vs, input bit v, input logic [31:0] p);
        i_vsync = vs;
        i_valid = v;
        i_pixel = p;
        if (rand_ready) dma_wready = ($urandom_range(3) != 0);
        if (vs && (m_cap || m_armed)) begin
            if (m_cap) emit(1'b1);
            m_cap = 1;
        end
        if (v && m_cap) begin
            frame_q.push_back(p);
            if (frame_q.size() == FP) begin
                emit(1'b0);
                m_cap = 0;
            end
        end
        @(posedge clk);
        #1;
        i_vsync = 1'b0;
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    task automatic drain();
        int budget;
        budget = 200;
        rand_ready = 0;
        dma_wready = 1'b1;
        idle(3);
        while (dma_wvalid && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        chk("drain_done", 80'(budget > 0), 80'(1));
        idle(2);
    endtask

    task automatic compare_words(input string tag);
        chk({tag, "_count"}, 80'(obs_q.size()), 80'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), (i < obs_q.size()) ? 80'(obs_q[i]) : '1, 80'(exp_q[i]));
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wvalid"}, 80'(dma_wvalid), 80'(0));
        chk({tag, "_word"}, 80'({dma_wlast, dma_wkeep, dma_wdata}), 80'(0));
        chk({tag, "_frames"}, 80'(o_frame_count), 80'(0));
        chk({tag, "_drops"}, 80'(o_drop_count), 80'(0));
        chk({tag, "_flags"}, 80'({o_overflow, o_short_frame}), 80'(0));
        chk({tag, "_busy"}, 80'(o_busy), 80'(0));
    endtask

    // Bus monitor: collects accepted words and checks stall stability
    initial begin
        logic        hv;
        logic [72:0] hw;
        hv = 1'b0;
        hw = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                hv = 1'b0;
            end else begin
                if (hv) chk("stall_hold", 80'({dma_wvalid, dma_wlast, dma_wkeep, dma_wdata}), 80'({1'b1, hw}));
                hv = dma_wvalid && !dma_wready;
                hw = {dma_wlast, dma_wkeep, dma_wdata};
                if (dma_wvalid && dma_wready) obs_q.push_back(hw);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard, got;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        resetn = 1'b1;
        idle(2);

        // disabled: vsync and pixels ignored
        step(1'b1, 1'b1, 32'h01010101);
        step(1'b0, 1'b1, 32'h02020202);
        step(1'b0, 1'b1, 32'h03030303);
        idle(3);
        chk("disabled_busy", 80'(o_busy), 80'(0));
        chk("disabled_words", 80'(obs_q.size()), 80'(0));

        // enable; pixel before vsync ignored; full 5-pixel frame
        i_enable = 1'b1;
        idle(2);
        m_armed = 1;
        chk("enabled_busy", 80'(o_busy), 80'(1));
        step(1'b0, 1'b1, 32'hDEADBEEF);
        step(1'b1, 1'b1, 32'h11111111);
        step(1'b0, 1'b1, 32'h22222222);
        step(1'b0, 1'b1, 32'h33333333);
        step(1'b0, 1'b1, 32'h44444444);
        step(1'b0, 1'b1, 32'h55555555);
        drain();
        chk("frame_w0_const", 80'(obs_q[0]), 80'({1'b0, 8'hFF, 64'h22222222_11111111}));
        chk("frame_w2_const", 80'(obs_q[2]), 80'({1'b1, 8'h0F, 64'h00000000_55555555}));
        compare_words("frame");
        chk("frame_count1", 80'(o_frame_count), 80'(m_frames));

        // early vsync: partial word, then empty-packer truncation, then full frame
        step(1'b1, 1'b1, 32'hAAAAAAAA);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 32'hB1B1B1B1);
        step(1'b0, 1'b1, 32'hB2B2B2B2);
        step(1'b1, 1'b1, 32'hC0C0C0C0);
        for (int i = 1; i < FP; i++) step(1'b0, 1'b1, 32'hC0C0C0C0 + i);
        drain();
        chk("short_w0_const", 80'(obs_q[0]), 80'({1'b1, 8'h0F, 64'h00000000_AAAAAAAA}));
        chk("short_w2_const", 80'(obs_q[2]), 80'({1'b1, 8'h00, 64'h0}));
        compare_words("short");
        chk("short_flag", 80'(o_short_frame), 80'(1));
        chk("short_frames", 80'(o_frame_count), 80'(m_frames));
        i_clear = 1'b1;
        idle(1);
        i_clear = 1'b0;
        idle(1);
        chk("short_cleared", 80'(o_short_frame), 80'(0));

        // overflow: 6 words into a 4-deep FIFO with the DMA stalled
        dma_wready = 1'b0;
        for (int f = 0; f < 2; f++) begin
            step(1'b1, 1'b1, $urandom);
            for (int i = 1; i < FP; i++) step(1'b0, 1'b1, $urandom);
        end
        idle(4);
        chk("ovf_flag", 80'(o_overflow), 80'(1));
        chk("ovf_drops", 80'(o_drop_count), 80'(2));
        chk("ovf_frames", 80'(o_frame_count), 80'(m_frames));
        chk("ovf_valid", 80'(dma_wvalid), 80'(1));
        chk("ovf_head", 80'({dma_wlast, dma_wkeep, dma_wdata}), 80'(exp_q[0]));
        i_clear = 1'b1;
        idle(1);
        i_clear = 1'b0;
        idle(1);
        chk("ovf_clear_drops", 80'(o_drop_count), 80'(0));
        chk("ovf_clear_flag", 80'(o_overflow), 80'(0));
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        drain();
        compare_words("ovf");

        // random valid and ready over three frames
        rand_ready = 1;
        for (int f = 0; f < 3; f++) begin
            step(1'b1, 1'b1, $urandom);
            got = 1;
            guard = 0;
            while (got < FP && guard < 1000) begin
                if ($urandom_range(2) == 0) begin
                    step(1'b0, 1'b1, $urandom);
                    got++;
                end else begin
                    step(1'b0, 1'b0, $urandom);
                end
                guard++;
            end
        end
        drain();
        compare_words("rand");
        chk("rand_drops", 80'(o_drop_count), 80'(0));
        chk("rand_frames", 80'(o_frame_count), 80'(m_frames));

        // async reset mid-frame with a word waiting in the FIFO
        dma_wready = 1'b0;
        step(1'b1, 1'b1, 32'h12345678);
        step(1'b0, 1'b1, 32'h9ABCDEF0);
        step(1'b0, 1'b1, 32'h0F0F0F0F);
        idle(2);
        chk("pre_reset_valid", 80'(dma_wvalid), 80'(1));
        resetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        frame_q.delete();
        exp_q.delete();
        obs_q.delete();
        m_cap = 0;
        m_armed = 0;
        m_frames = '0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        dma_wready = 1'b1;
        idle(2);
        m_armed = 1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h77770000 + i);
        idle(3);
        chk("post_reset_words", 80'(obs_q.size()), 80'(0));
        step(1'b1, 1'b1, 32'hE0E0E0E0);
        for (int i = 1; i < FP; i++) step(1'b0, 1'b1, 32'hE0E0E0E0 + i);
        drain();
        compare_words("post_reset");
        chk("post_reset_frames", 80'(o_frame_count), 80'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
